// File: rtl/xor_vector_gate.sv
// ============================================================================
// xor_vector_gate
// ----------------------------------------------------------------------------
// Sequenced element-wise XOR of two operand vectors. The block requests one
// A/B element pair at a time from upstream producers (DATA_ENABLE). It accepts
// the two operand streams independently, in any order. It returns one
// registered XOR result per element with a one-cycle strobe, and it pulses
// READY once the whole vector has been processed.
//
// Ports
//   CLK               in   clock, all logic on the rising edge
//   RST               in   synchronous, active-high reset
//   START             in   start a vector operation (sampled only when idle)
//   READY             out  one-cycle pulse when a vector completes
//   SIZE_IN           in   element count, latched when START is accepted
//   DATA_A_IN_ENABLE  in   DATA_A_IN holds a valid element
//   DATA_B_IN_ENABLE  in   DATA_B_IN holds a valid element
//   DATA_A_IN         in   operand A element
//   DATA_B_IN         in   operand B element
//   DATA_ENABLE       out  request for the next A/B element pair
//   DATA_OUT_ENABLE   out  one-cycle strobe, DATA_OUT is valid
//   DATA_OUT          out  registered DATA_A_IN ^ DATA_B_IN
// ============================================================================
module xor_vector_gate #(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 64
) (
    input  logic                    CLK,
    input  logic                    RST,

    input  logic                    START,
    output logic                    READY,

    input  logic [CONTROL_SIZE-1:0] SIZE_IN,

    input  logic                    DATA_A_IN_ENABLE,
    input  logic                    DATA_B_IN_ENABLE,
    input  logic [DATA_SIZE-1:0]    DATA_A_IN,
    input  logic [DATA_SIZE-1:0]    DATA_B_IN,

    output logic                    DATA_ENABLE,
    output logic                    DATA_OUT_ENABLE,
    output logic [DATA_SIZE-1:0]    DATA_OUT
);

    typedef enum logic [1:0] {
        STARTER = 2'd0,
        INPUT   = 2'd1,
        ENDER   = 2'd2
    } state_t;

    state_t                  state_reg;

    logic [CONTROL_SIZE-1:0] index_reg;
    logic [CONTROL_SIZE-1:0] size_reg;

    // Each operand is captured once per element. The flag marks it as held,
    // so that later enables for the same operand are ignored (first wins).
    logic                    flag_a_reg;
    logic                    flag_b_reg;
    logic [DATA_SIZE-1:0]    data_a_reg;
    logic [DATA_SIZE-1:0]    data_b_reg;

    logic                    ready_reg;
    logic                    data_enable_reg;
    logic                    data_out_enable_reg;
    logic [DATA_SIZE-1:0]    data_out_reg;

    // ------------------------------------------------------------------------
    // Operand selection: a pair completes in the same cycle that its last
    // operand arrives. A held operand takes priority over the live input.
    // ------------------------------------------------------------------------
    logic                    have_a;
    logic                    have_b;
    logic                    pair_done;
    logic                    last_element;
    logic [DATA_SIZE-1:0]    operand_a;
    logic [DATA_SIZE-1:0]    operand_b;
    logic [DATA_SIZE-1:0]    xor_word;

    assign have_a       = flag_a_reg | DATA_A_IN_ENABLE;
    assign have_b       = flag_b_reg | DATA_B_IN_ENABLE;
    assign pair_done    = have_a & have_b;
    assign operand_a    = flag_a_reg ? data_a_reg : DATA_A_IN;
    assign operand_b    = flag_b_reg ? data_b_reg : DATA_B_IN;
    assign last_element = (index_reg == (size_reg - CONTROL_SIZE'(1)));

    // Pure bitwise XOR, no carry chain between lanes.
    generate
        for (genvar gi = 0; gi < DATA_SIZE; gi++) begin : g_xor_lane
            assign xor_word[gi] = operand_a[gi] ^ operand_b[gi];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Control FSM and all registered outputs.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg           <= STARTER;
            index_reg           <= '0;
            size_reg            <= '0;
            flag_a_reg          <= 1'b0;
            flag_b_reg          <= 1'b0;
            data_a_reg          <= '0;
            data_b_reg          <= '0;
            ready_reg           <= 1'b0;
            data_enable_reg     <= 1'b0;
            data_out_enable_reg <= 1'b0;
            data_out_reg        <= '0;
        end else begin
            // READY and the output strobe are single-cycle pulses.
            ready_reg           <= 1'b0;
            data_out_enable_reg <= 1'b0;

            case (state_reg)
                STARTER: begin
                    if (START) begin
                        if (SIZE_IN != '0) begin
                            size_reg        <= SIZE_IN;
                            index_reg       <= '0;
                            data_enable_reg <= 1'b1;
                            state_reg       <= INPUT;
                        end else begin
                            // An empty vector completes immediately.
                            ready_reg <= 1'b1;
                        end
                    end
                end

                INPUT: begin
                    if (!flag_a_reg && DATA_A_IN_ENABLE) begin
                        data_a_reg <= DATA_A_IN;
                        flag_a_reg <= 1'b1;
                    end
                    if (!flag_b_reg && DATA_B_IN_ENABLE) begin
                        data_b_reg <= DATA_B_IN;
                        flag_b_reg <= 1'b1;
                    end
                    // The flag clears below override the sets above when the
                    // pair completes in the same cycle.
                    if (pair_done) begin
                        data_out_reg        <= xor_word;
                        data_out_enable_reg <= 1'b1;
                        data_enable_reg     <= 1'b0;
                        flag_a_reg          <= 1'b0;
                        flag_b_reg          <= 1'b0;
                        state_reg           <= ENDER;
                    end
                end

                ENDER: begin
                    if (last_element) begin
                        ready_reg <= 1'b1;
                        state_reg <= STARTER;
                    end else begin
                        index_reg       <= index_reg + CONTROL_SIZE'(1);
                        data_enable_reg <= 1'b1;
                        state_reg       <= INPUT;
                    end
                end

                default: begin
                    state_reg <= STARTER;
                end
            endcase
        end
    end

    assign READY           = ready_reg;
    assign DATA_ENABLE     = data_enable_reg;
    assign DATA_OUT_ENABLE = data_out_enable_reg;
    assign DATA_OUT        = data_out_reg;

endmodule
